platform_pio_switch_ctrl: RTL and testbench
===========================================

PLATFORM_PIO_SWITCH_CTRL -- requirements
Module: platform_pio_switch_ctrl

Interface
REQ-001 Parameter WIDTH, default 4: number of switch inputs, 1..32.
REQ-002 Parameter DEBOUNCE_CYCLES, default 50000: consecutive cycles a synchronized input must differ from the accepted value before that value changes; range 2..2^20.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 address  input  2  register select: 0 DATA, 1 IRQMASK, 2 EDGECAP, 3 CTRL.
REQ-006 chipselect  input  1  slave select; qualifies write.
REQ-007 write  input  1  active-high write strobe, effective only with chipselect=1.
REQ-008 writedata  input  32  write data.
REQ-009 in_port  input  WIDTH  raw, asynchronous switch levels.
REQ-010 readdata  output  32  registered read data.
REQ-011 irq  output  1  level interrupt, active-high.

Function
REQ-012 in_port SHALL pass through a 2-flop synchronizer per bit; the second-stage output is "sync".
REQ-013 Each bit SHALL have an accepted value "stable" and a counter, CNT_W = clog2(DEBOUNCE_CYCLES) bits.
REQ-014 Per-bit counter: sync==stable -> counter cleared to 0; sync!=stable and counter<DEBOUNCE_CYCLES-1 -> increment; sync!=stable and counter==DEBOUNCE_CYCLES-1 -> stable<=sync, counter<=0.
REQ-015 A glitch shorter than DEBOUNCE_CYCLES cycles at sync SHALL never change stable; any single return to the old value restarts the count from 0.
REQ-016 Latency from a clean in_port change to stable change SHALL be exactly 2+DEBOUNCE_CYCLES cycles.
REQ-017 CTRL[1:0] selects capture edge: 00 rising, 01 falling, 1x both; CTRL[31:2] read 0, writes ignored.
REQ-018 EDGECAP[i] SHALL set in the cycle after stable[i] makes a transition matching CTRL mode, and hold until cleared.
REQ-019 Write to EDGECAP SHALL clear each bit whose writedata bit is 1 (write-1-to-clear); 0 bits unaffected.
REQ-020 Simultaneous set and write-1-clear on the same bit in the same cycle: set wins, bit stays 1.
REQ-021 IRQMASK[WIDTH-1:0] is read/write; upper bits read 0.
REQ-022 irq SHALL equal |(EDGECAP & IRQMASK), combinational from registers, no extra latency.
REQ-023 Writes to DATA SHALL be ignored.
REQ-024 readdata SHALL be registered every clk cycle from the register selected by address (DATA returns stable), zero-extended to 32 bits; read latency exactly 1 cycle, no read strobe.
REQ-025 A CTRL write takes effect for transitions of stable occurring in the cycle after the write; transitions in the write cycle use the old mode.
REQ-026 Multiple bits may become stable and capture in the same cycle; each bit is independent.

Reset
REQ-027 reset=1 SHALL asynchronously clear synchronizer flops, stable, counters, IRQMASK, EDGECAP, CTRL, readdata; irq=0.
REQ-028 After reset release, stable starts at 0; switches already high SHALL be accepted after 2+DEBOUNCE_CYCLES cycles and SHALL produce a rising-edge capture.
REQ-029 Reset asserted mid-count SHALL discard the count; no capture results from the aborted count.

Verification (DEBOUNCE_CYCLES=4, WIDTH=4)
REQ-030 in_port 0000->0001 held; read DATA each cycle -> DATA=0x1 visible on readdata 7 cycles after the change (2 sync + 4 debounce + 1 read).
REQ-031 in_port[0] pulses high 3 cycles then low -> DATA stays 0x0, EDGECAP stays 0x0, irq stays 0.
REQ-032 IRQMASK=0x1, CTRL=00, bit0 rises cleanly -> EDGECAP=0x1, irq=1; write EDGECAP 0x1 -> EDGECAP=0x0, irq=0 next cycle.
REQ-033 CTRL=01, bit2 rises then falls (each held 6 cycles) -> only falling sets EDGECAP=0x4; IRQMASK=0 -> irq stays 0 despite EDGECAP=0x4.
REQ-034 Write-1-clear of bit1 in the exact cycle bit1 captures -> EDGECAP[1]=1 after the cycle.
REQ-035 Reset pulsed while bit3 counter=2 -> after release all registers read 0, irq=0; bit3 still high accepted 6 cycles after release.

Source files
------------

// File: rtl/platform_pio_switch_ctrl.sv
// Debounced switch PIO: per-bit 2-flop sync plus a debounce counter, edge capture with
// write-1-to-clear, an interrupt mask, and a one-cycle registered read port.
module platform_pio_switch_ctrl #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_IRQMASK = 2'd1;
  localparam logic [1:0] ADDR_EDGECAP = 2'd2;
  localparam logic [1:0] ADDR_CTRL    = 2'd3;

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [WIDTH-1:0] r_stable;
  logic [CNT_W-1:0] r_cnt [WIDTH];
  logic [WIDTH-1:0] r_hit;
  logic [WIDTH-1:0] r_edgecap;
  logic [WIDTH-1:0] r_irqmask;
  logic [1:0]       r_ctrl;

  logic [WIDTH-1:0] w_stable_nxt;
  logic [CNT_W-1:0] w_cnt_nxt [WIDTH];
  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_fall;
  logic [WIDTH-1:0] w_match;
  logic [WIDTH-1:0] w_clr;
  logic             w_wr;
  logic [31:0]      w_rd;
  logic             w_unused_wd;

  assign w_wr        = chipselect & write;
  assign w_unused_wd = ^writedata;

  // Any sample equal to the accepted value restarts the count, so short glitches never land.
  always_comb begin
    w_stable_nxt = r_stable;
    for (int i = 0; i < WIDTH; i++) begin
      w_cnt_nxt[i] = '0;
      if (r_sync2[i] != r_stable[i]) begin
        if (r_cnt[i] == CNT_MAX) begin
          w_stable_nxt[i] = r_sync2[i];
        end else begin
          w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Mode is sampled at the transition edge so a same-cycle CTRL write still sees the old mode.
  always_comb begin
    w_rise  = w_stable_nxt & ~r_stable;
    w_fall  = ~w_stable_nxt & r_stable;
    w_match = r_ctrl[1] ? (w_rise | w_fall) : (r_ctrl[0] ? w_fall : w_rise);
    w_clr   = (w_wr && address == ADDR_EDGECAP) ? writedata[WIDTH-1:0] : '0;
  end

  always_comb begin
    w_rd = '0;
    case (address)
      ADDR_DATA:    w_rd = 32'(r_stable);
      ADDR_IRQMASK: w_rd = 32'(r_irqmask);
      ADDR_EDGECAP: w_rd = 32'(r_edgecap);
      ADDR_CTRL:    w_rd = 32'(r_ctrl);
      default:      w_rd = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1  <= '0;
      r_sync2  <= '0;
      r_stable <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_sync1  <= in_port;
      r_sync2  <= r_sync1;
      r_stable <= w_stable_nxt;
      for (int i = 0; i < WIDTH; i++) begin
        r_cnt[i] <= w_cnt_nxt[i];
      end
    end
  end

  // A capture landing in the same cycle as its clear wins, so the OR comes after the mask.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hit     <= '0;
      r_edgecap <= '0;
      r_irqmask <= '0;
      r_ctrl    <= '0;
      readdata  <= '0;
    end else begin
      r_hit     <= w_match;
      r_edgecap <= (r_edgecap & ~w_clr) | r_hit;
      readdata  <= w_rd;
      if (w_wr && address == ADDR_IRQMASK) begin
        r_irqmask <= writedata[WIDTH-1:0];
      end
      if (w_wr && address == ADDR_CTRL) begin
        r_ctrl <= writedata[1:0];
      end
    end
  end

  assign irq = |(r_edgecap & r_irqmask);

endmodule

// File: tb/tb_platform_pio_switch_ctrl.sv
// Bench for platform_pio_switch_ctrl: directed scenarios and random traffic, each cycle
// compared against a window-based reference model of the debounce and capture rules.
module tb_platform_pio_switch_ctrl;

  localparam int W = 4;
  localparam int D = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [1:0]    address = '0;
  logic          chipselect = 1'b0;
  logic          write = 1'b0;
  logic [31:0]   writedata = '0;
  logic [W-1:0]  in_port = '0;
  logic [31:0]   readdata;
  logic          irq;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  logic [W-1:0] m_s1, m_s2, m_stable, m_cap, m_mask, m_pend;
  logic [W-1:0] m_hist [D];
  logic [1:0]   m_ctrl;
  logic [31:0]  m_rd;
  logic         m_irq;

  platform_pio_switch_ctrl #(.WIDTH(W), .DEBOUNCE_CYCLES(D)) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write      (write),
    .writedata  (writedata),
    .in_port    (in_port),
    .readdata   (readdata),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_stable = '0; m_cap = '0; m_mask = '0; m_pend = '0;
    m_ctrl = '0; m_rd = '0; m_irq = 1'b0;
    for (int j = 0; j < D; j++) m_hist[j] = '0;
  endtask

  // stable flips once the last D synchronized samples all disagree with it
  task automatic model_step();
    logic [W-1:0] sync_now, nst, rise, fall, pend, clr;
    logic         all_diff;
    sync_now = m_s2;
    m_s2 = m_s1;
    m_s1 = in_port;
    for (int j = 0; j < D - 1; j++) m_hist[j] = m_hist[j+1];
    m_hist[D-1] = sync_now;
    nst = m_stable;
    for (int b = 0; b < W; b++) begin
      all_diff = 1'b1;
      for (int j = 0; j < D; j++) if (m_hist[j][b] == m_stable[b]) all_diff = 1'b0;
      if (all_diff) nst[b] = ~m_stable[b];
    end
    rise = nst & ~m_stable;
    fall = ~nst & m_stable;
    if (m_ctrl[1])      pend = rise | fall;
    else if (m_ctrl[0]) pend = fall;
    else                pend = rise;
    case (address)
      2'd0: m_rd = {28'd0, m_stable};
      2'd1: m_rd = {28'd0, m_mask};
      2'd2: m_rd = {28'd0, m_cap};
      default: m_rd = {30'd0, m_ctrl};
    endcase
    clr = (chipselect && write && address == 2'd2) ? writedata[W-1:0] : '0;
    m_cap  = (m_cap & ~clr) | m_pend;
    m_pend = pend;
    if (chipselect && write && address == 2'd1) m_mask = writedata[W-1:0];
    if (chipselect && write && address == 2'd3) m_ctrl = writedata[1:0];
    m_stable = nst;
    m_irq = |(m_cap & m_mask);
  endtask

  task automatic cyc(input logic r, input logic [1:0] a, input logic cs, input logic wr,
                     input logic [31:0] wd, input logic [W-1:0] inp);
    @(negedge clk);
    reset = r; address = a; chipselect = cs; write = wr; writedata = wd; in_port = inp;
    @(posedge clk);
    if (r) model_reset(); else model_step();
    #1;
    chk("readdata", readdata, m_rd);
    chk("irq", {31'd0, irq}, {31'd0, m_irq});
  endtask

  task automatic do_reset();
    cyc(1'b1, 2'd0, 1'b0, 1'b0, 32'd0, '0);
    cyc(1'b1, 2'd0, 1'b0, 1'b0, 32'd0, '0);
  endtask

  initial begin
    int lat;
    logic seen;
    logic [W-1:0] cur;
    model_reset();

    // clean rise on bit0: DATA visible 7 cycles after the change
    do_reset();
    lat = 0;
    for (int i = 1; i <= 12; i++) begin
      cyc(1'b0, 2'd0, 1'b0, 1'b0, 32'd0, 4'h1);
      if (readdata == 32'h1 && lat == 0) lat = i;
    end
    chk("lat_data", lat, 7);

    // 3-cycle glitch on bit0 is never accepted
    do_reset();
    seen = 1'b0;
    for (int i = 0; i < 3; i++) cyc(1'b0, 2'd0, 1'b0, 1'b0, 32'd0, 4'h1);
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, 2'd0, 1'b0, 1'b0, 32'd0, 4'h0);
      if (readdata != 32'd0 || irq) seen = 1'b1;
    end
    chk("glitch_data", {31'd0, seen}, 32'd0);
    cyc(1'b0, 2'd2, 1'b0, 1'b0, 32'd0, 4'h0);
    cyc(1'b0, 2'd2, 1'b0, 1'b0, 32'd0, 4'h0);
    chk("glitch_cap", readdata, 32'd0);

    // masked rising capture raises irq; write-1-clear drops it
    do_reset();
    cyc(1'b0, 2'd1, 1'b1, 1'b1, 32'h1, 4'h0);
    for (int i = 0; i < 8; i++) cyc(1'b0, 2'd2, 1'b0, 1'b0, 32'd0, 4'h1);
    chk("rise_cap", readdata, 32'h1);
    chk("rise_irq", {31'd0, irq}, 32'd1);
    cyc(1'b0, 2'd2, 1'b1, 1'b1, 32'h1, 4'h1);
    chk("clr_irq", {31'd0, irq}, 32'd0);
    cyc(1'b0, 2'd2, 1'b0, 1'b0, 32'd0, 4'h1);
    chk("clr_cap", readdata, 32'd0);

    // falling-only mode on bit2, unmasked
    do_reset();
    cyc(1'b0, 2'd3, 1'b1, 1'b1, 32'hFFFF_FFFD, 4'h0);
    cyc(1'b0, 2'd3, 1'b0, 1'b0, 32'd0, 4'h0);
    chk("ctrl_rd", readdata, 32'h1);
    for (int i = 0; i < 6; i++) cyc(1'b0, 2'd2, 1'b0, 1'b0, 32'd0, 4'h4);
    for (int i = 0; i < 6; i++) cyc(1'b0, 2'd2, 1'b0, 1'b0, 32'd0, 4'h0);
    chk("fall_nocap_yet", readdata, 32'd0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 2'd2, 1'b0, 1'b0, 32'd0, 4'h0);
    chk("fall_cap", readdata, 32'h4);
    chk("fall_irq", {31'd0, irq}, 32'd0);

    // clear in the very cycle bit1 captures: capture wins
    do_reset();
    for (int i = 0; i < 6; i++) cyc(1'b0, 2'd0, 1'b0, 1'b0, 32'd0, 4'h2);
    cyc(1'b0, 2'd2, 1'b1, 1'b1, 32'h2, 4'h2);
    cyc(1'b0, 2'd2, 1'b0, 1'b0, 32'd0, 4'h2);
    chk("set_wins", readdata, 32'h2);

    // reset mid-count on bit3, then re-acceptance from scratch
    do_reset();
    cyc(1'b0, 2'd1, 1'b1, 1'b1, 32'hF, 4'h8);
    for (int i = 0; i < 3; i++) cyc(1'b0, 2'd0, 1'b0, 1'b0, 32'd0, 4'h8);
    cyc(1'b1, 2'd0, 1'b0, 1'b0, 32'd0, 4'h8);
    chk("rst_rd", readdata, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    for (int i = 1; i <= 7; i++) begin
      cyc(1'b0, 2'd0, 1'b0, 1'b0, 32'd0, 4'h8);
      if (i == 6) chk("rst_data_pre", readdata, 32'd0);
    end
    chk("rst_data_post", readdata, 32'h8);
    cyc(1'b0, 2'd2, 1'b0, 1'b0, 32'd0, 4'h8);
    cyc(1'b0, 2'd2, 1'b0, 1'b0, 32'd0, 4'h8);
    chk("rst_cap", readdata, 32'h8);

    // random traffic against the model
    do_reset();
    cur = '0;
    for (int i = 0; i < 3000; i++) begin
      logic [W-1:0] flip;
      logic         go;
      for (int b = 0; b < W; b++) flip[b] = ($urandom_range(0, 5) == 0);
      cur = cur ^ flip;
      go = ($urandom_range(0, 3) == 0);
      cyc(($urandom_range(0, 399) == 0), 2'($urandom_range(0, 3)), go | $urandom_range(0, 1),
          go, $urandom, cur);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
